// File: rtl/ripemd160_core_par_if.sv
// RIPEMD-160 core handshake bundle: block request side and digest result side.
// The master drives init/next/block; the core (slave) returns ready/digest.
interface ripemd160_core_par_if;
    logic         init;
    logic         next;
    logic [511:0] block;
    logic         ready;
    logic [159:0] digest;
    logic         digest_valid;

    modport master (
        output init, next, block,
        input  ready, digest, digest_valid
    );

    modport slave (
        input  init, next, block,
        output ready, digest, digest_valid
    );
endinterface

// File: rtl/ripemd160_core_par.sv
// RIPEMD-160 compression core, both lines in parallel, ROUNDS_PER_CYCLE steps per clock.
// Define RIPEMD160_BSWAP_EN to present the digest as canonical bytes instead of raw words.
module ripemd160_core_par #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    ripemd160_core_par_if.slave  bus
);

    localparam int NCYC = 80 / ROUNDS_PER_CYCLE;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 5 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 10 ||
          ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 5, 8, 10 or 16");
    end

    // Element 0 is A (working sets) or H0 (chaining value).
    typedef logic [4:0][31:0]  wset_t;
    typedef logic [15:0][31:0] xblk_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUNDS,
        DONE
    } state_t;

    localparam wset_t IV = {
        32'hc3d2e1f0, 32'h10325476, 32'h98badcfe,
        32'hefcdab89, 32'h67452301
    };

    localparam int RL [80] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
        3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
        1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
        4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13
    };

    localparam int RR [80] = '{
        5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
        6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
        15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
        8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
        12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11
    };

    localparam int SL [80] = '{
        11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
        7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
        11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
        11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
        9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6
    };

    localparam int SR [80] = '{
        8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
        9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
        9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
        15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
        8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11
    };

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] t;
        t = {v, v} << s;
        return t[63:32];
    endfunction

    function automatic logic [31:0] fsel(
        input logic [2:0]  n,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        case (n)
            3'd1:    return x ^ y ^ z;
            3'd2:    return (x & y) | (~x & z);
            3'd3:    return (x | ~y) ^ z;
            3'd4:    return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [31:0] kl(input logic [2:0] rnd);
        case (rnd)
            3'd0:    return 32'h00000000;
            3'd1:    return 32'h5a827999;
            3'd2:    return 32'h6ed9eba1;
            3'd3:    return 32'h8f1bbcdc;
            default: return 32'ha953fd4e;
        endcase
    endfunction

    function automatic logic [31:0] kr(input logic [2:0] rnd);
        case (rnd)
            3'd0:    return 32'h50a28be6;
            3'd1:    return 32'h5c4dd124;
            3'd2:    return 32'h6d703ef3;
            3'd3:    return 32'h7a6d76e9;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic wset_t step(
        input wset_t      w,
        input logic [6:0] j,
        input logic       right,
        input xblk_t      x
    );
        logic [2:0]  rnd;
        logic [31:0] f;
        logic [31:0] k;
        logic [31:0] t;
        logic [3:0]  idx;
        logic [4:0]  sh;
        rnd = j[6:4];
        if (right) begin
            f   = fsel(3'(3'd5 - rnd), w[1], w[2], w[3]);
            k   = kr(rnd);
            idx = 4'(RR[j]);
            sh  = 5'(SR[j]);
        end else begin
            f   = fsel(3'(rnd + 3'd1), w[1], w[2], w[3]);
            k   = kl(rnd);
            idx = 4'(RL[j]);
            sh  = 5'(SL[j]);
        end
        t = rol(w[0] + f + x[idx] + k, sh) + w[4];
        return {w[3], rol(w[2], 5'd10), w[1], t, w[4]};
    endfunction

    state_t       state_q;
    state_t       state_d;
    logic [6:0]   cnt;
    logic [6:0]   base;
    logic [511:0] blk_q;
    xblk_t        xw;
    wset_t        h_q;
    wset_t        h_n;
    wset_t        l_q;
    wset_t        r_q;
    wset_t        l_n;
    wset_t        r_n;
    logic         dv;
    logic         go;
    logic         last;

    assign go   = bus.init | bus.next;
    assign last = (cnt == 7'(NCYC - 1));
    assign base = 7'(int'(cnt) * ROUNDS_PER_CYCLE);

    // Message words are little-endian within the big-endian byte stream.
    always_comb begin
        xw = '0;
        for (int i = 0; i < 16; i++) begin
            xw[i] = bswap(blk_q[511 - 32*i -: 32]);
        end
    end

    always_comb begin
        l_n = l_q;
        r_n = r_q;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            l_n = step(l_n, 7'(int'(base) + k), 1'b0, xw);
            r_n = step(r_n, 7'(int'(base) + k), 1'b1, xw);
        end
    end

    always_comb begin
        h_n    = '0;
        h_n[0] = h_q[1] + l_q[2] + r_q[3];
        h_n[1] = h_q[2] + l_q[3] + r_q[4];
        h_n[2] = h_q[3] + l_q[4] + r_q[0];
        h_n[3] = h_q[4] + l_q[0] + r_q[1];
        h_n[4] = h_q[0] + l_q[1] + r_q[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus.ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                if (go) begin
                    state_d = ROUNDS;
                end
            end
            ROUNDS: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q   <= '0;
            l_q   <= '0;
            r_q   <= '0;
            blk_q <= '0;
            cnt   <= '0;
            dv    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        blk_q <= bus.block;
                        cnt   <= '0;
                        dv    <= 1'b0;
                        if (bus.init) begin
                            h_q <= IV;
                            l_q <= IV;
                            r_q <= IV;
                        end else begin
                            l_q <= h_q;
                            r_q <= h_q;
                        end
                    end
                end
                ROUNDS: begin
                    l_q <= l_n;
                    r_q <= r_n;
                    cnt <= cnt + 7'd1;
                end
                DONE: begin
                    h_q <= h_n;
                    dv  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.digest_valid = dv;

`ifdef RIPEMD160_BSWAP_EN
    assign bus.digest = {
        bswap(h_q[0]), bswap(h_q[1]), bswap(h_q[2]),
        bswap(h_q[3]), bswap(h_q[4])
    };
`else
    assign bus.digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
`endif

endmodule

// File: tb/tb_ripemd160_core_par.sv
// Bench for ripemd160_core_par: cores at 1 and 5 steps/clock run side by side
// against known vectors and a behavioural RIPEMD-160 model.
module tb_ripemd160_core_par;

    typedef logic [4:0][31:0] hv_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst5;
    int   checks = 0;
    int   failures = 0;
    hv_t  hm;

    always #5 clk = ~clk;

    ripemd160_core_par_if if1 ();
    ripemd160_core_par_if if5 ();

    ripemd160_core_par #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
    );

    ripemd160_core_par #(.ROUNDS_PER_CYCLE(5)) dut5 (
        .clk   (clk),
        .reset (rst5),
        .bus   (if5)
    );

    localparam hv_t IV = {
        32'hc3d2e1f0, 32'h10325476, 32'h98badcfe,
        32'hefcdab89, 32'h67452301
    };

    int ZL [80] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
        3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
        1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
        4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13
    };
    int ZR [80] = '{
        5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
        6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
        15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
        8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
        12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11
    };
    int QL [80] = '{
        11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
        7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
        11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
        11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
        9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6
    };
    int QR [80] = '{
        8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
        9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
        9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
        15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
        8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11
    };
    logic [31:0] KL [5] = '{32'h0, 32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'ha953fd4e};
    logic [31:0] KR [5] = '{32'h50a28be6, 32'h5c4dd124, 32'h6d703ef3, 32'h7a6d76e9, 32'h0};

    function automatic logic [31:0] bsw(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] fn(input int n, input logic [31:0] x, y, z);
        if (n == 1) return x ^ y ^ z;
        if (n == 2) return (x & y) | (~x & z);
        if (n == 3) return (x | ~y) ^ z;
        if (n == 4) return (x & z) | (y & ~z);
        return x ^ (y | ~z);
    endfunction

    function automatic hv_t compress(input hv_t h, input logic [511:0] blk);
        logic [31:0] x [16];
        logic [31:0] al, bl, cl, dl, el, ar, br, cr, dr, er, t;
        hv_t res;
        int rd;
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < 4; b++)
                x[i][8*b +: 8] = blk[511 - 8*(4*i + b) -: 8];
        al = h[0]; bl = h[1]; cl = h[2]; dl = h[3]; el = h[4];
        ar = h[0]; br = h[1]; cr = h[2]; dr = h[3]; er = h[4];
        for (int j = 0; j < 80; j++) begin
            rd = j / 16;
            t = rotl(al + fn(rd + 1, bl, cl, dl) + x[ZL[j]] + KL[rd], QL[j]) + el;
            al = el; el = dl; dl = rotl(cl, 10); cl = bl; bl = t;
            t = rotl(ar + fn(5 - rd, br, cr, dr) + x[ZR[j]] + KR[rd], QR[j]) + er;
            ar = er; er = dr; dr = rotl(cr, 10); cr = br; br = t;
        end
        res[0] = h[1] + cl + dr;
        res[1] = h[2] + dl + er;
        res[2] = h[3] + el + ar;
        res[3] = h[4] + al + br;
        res[4] = h[0] + bl + cr;
        return res;
    endfunction

    function automatic logic [159:0] shown(input hv_t h);
`ifdef RIPEMD160_BSWAP_EN
        return {bsw(h[0]), bsw(h[1]), bsw(h[2]), bsw(h[3]), bsw(h[4])};
`else
        return {h[0], h[1], h[2], h[3], h[4]};
`endif
    endfunction

    function automatic logic [159:0] canon(input logic [159:0] c);
`ifdef RIPEMD160_BSWAP_EN
        return c;
`else
        return {bsw(c[159:128]), bsw(c[127:96]), bsw(c[95:64]),
                bsw(c[63:32]), bsw(c[31:0])};
`endif
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic i, input logic n, input logic [511:0] b);
        if1.init = i; if1.next = n; if1.block = b;
        if5.init = i; if5.next = n; if5.block = b;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rdy1"}, 160'(if1.ready), 160'(1));
        chk({tag, "_dv1"}, 160'(if1.digest_valid), 160'(0));
        chk({tag, "_dig1"}, if1.digest, 160'(0));
        chk({tag, "_rdy5"}, 160'(if5.ready), 160'(1));
        chk({tag, "_dv5"}, 160'(if5.digest_valid), 160'(0));
        chk({tag, "_dig5"}, if5.digest, 160'(0));
    endtask

    // One block on both cores; ab1/ab5 = cycle at which reset hits (0 = none).
    task automatic run_block(
        input string        tag,
        input bit           is_init,
        input logic [511:0] blk,
        input bit           use_k,
        input logic [159:0] kdig,
        input bit           glitch,
        input int           ab1,
        input int           ab5
    );
        hv_t hx;
        logic [159:0] exp;
        hx  = compress(is_init ? IV : hm, blk);
        exp = use_k ? canon(kdig) : shown(hx);
        drive(is_init, !is_init, blk);
        @(posedge clk); #1;
        chk({tag, "_acc_rdy1"}, 160'(if1.ready), 160'(0));
        chk({tag, "_acc_dv1"}, 160'(if1.digest_valid), 160'(0));
        chk({tag, "_acc_rdy5"}, 160'(if5.ready), 160'(0));
        chk({tag, "_acc_dv5"}, 160'(if5.digest_valid), 160'(0));
        drive(1'b0, 1'b0, blk);
        for (int c = 1; c <= 81; c++) begin
            if (glitch && c == 10) drive(1'b1, 1'b0, rand_blk());
            if (glitch && c == 11) drive(1'b0, 1'b0, rand_blk());
            rst5 = (c == ab5);
            rst1 = (c == ab1);
            @(posedge clk); #1;
            if (c == ab5) begin
                chk({tag, "_rst_rdy5"}, 160'(if5.ready), 160'(1));
                chk({tag, "_rst_dv5"}, 160'(if5.digest_valid), 160'(0));
                chk({tag, "_rst_dig5"}, if5.digest, 160'(0));
            end else if (ab5 == 0 || c < ab5) begin
                if (c < 17) begin
                    chk({tag, "_busy5"}, 160'(if5.ready), 160'(0));
                end else if (c == 17) begin
                    chk({tag, "_rdy5"}, 160'(if5.ready), 160'(1));
                    chk({tag, "_dv5"}, 160'(if5.digest_valid), 160'(1));
                    chk({tag, "_dig5"}, if5.digest, exp);
                end
            end
            if (c == ab1) begin
                chk({tag, "_rst_rdy1"}, 160'(if1.ready), 160'(1));
                chk({tag, "_rst_dv1"}, 160'(if1.digest_valid), 160'(0));
                chk({tag, "_rst_dig1"}, if1.digest, 160'(0));
            end else if (ab1 == 0 || c < ab1) begin
                if (c < 81) begin
                    chk({tag, "_busy1"}, 160'(if1.ready), 160'(0));
                end else begin
                    chk({tag, "_rdy1"}, 160'(if1.ready), 160'(1));
                    chk({tag, "_dv1"}, 160'(if1.digest_valid), 160'(1));
                    chk({tag, "_dig1"}, if1.digest, exp);
                end
            end
        end
        rst1 = 1'b0;
        rst5 = 1'b0;
        hm = (ab1 != 0) ? hv_t'(0) : hx;
    endtask

    initial begin
        logic [511:0] b_empty;
        logic [511:0] b_abc;
        logic [511:0] b_m1;
        logic [511:0] b_m2;
        string m;

        b_empty = {8'h80, 504'h0};
        b_abc   = {32'h61626380, 416'h0, 8'h18, 56'h0};
        m = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        b_m1 = '0;
        for (int i = 0; i < 56; i++) b_m1[511 - 8*i -: 8] = m[i];
        b_m1[63:56] = 8'h80;
        b_m2 = '0;
        b_m2[63:56] = 8'hc0;
        b_m2[55:48] = 8'h01;

        drive(1'b0, 1'b0, '0);
        rst1 = 1'b1;
        rst5 = 1'b1;
        hm = '0;
        repeat (2) @(posedge clk);
        #1;
        idle_chk("reset");
        rst1 = 1'b0;
        rst5 = 1'b0;
        @(posedge clk); #1;
        idle_chk("idle");

        run_block("empty", 1'b1, b_empty, 1'b1,
                  160'h9c1185a5c5e9fc54612808977ee8f548b2258d31, 1'b0, 0, 0);
        run_block("abc_glitch", 1'b1, b_abc, 1'b1,
                  160'h8eb208f7e05d987a9b044a8e98c6b087f15a0bfc, 1'b1, 0, 0);
        run_block("two_a", 1'b1, b_m1, 1'b0, '0, 1'b0, 0, 0);
        run_block("two_b", 1'b0, b_m2, 1'b1,
                  160'h12a053384a9c0c88e405a06c27dcf49ada62eb2b, 1'b0, 0, 0);
        run_block("rnd_init", 1'b1, rand_blk(), 1'b0, '0, 1'b0, 0, 0);
        run_block("rnd_next1", 1'b0, rand_blk(), 1'b0, '0, 1'b0, 0, 0);
        run_block("rnd_next2", 1'b0, rand_blk(), 1'b0, '0, 1'b0, 0, 0);
        run_block("abort", 1'b1, rand_blk(), 1'b0, '0, 1'b0, 40, 8);
        run_block("next_h0", 1'b0, rand_blk(), 1'b0, '0, 1'b0, 0, 0);
        run_block("empty_again", 1'b1, b_empty, 1'b1,
                  160'h9c1185a5c5e9fc54612808977ee8f548b2258d31, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
